// File: rtl/serial_tx_arbiter_pkg.sv
// Shared constants and FSM state type for the serial transmitter arbiter.
package serial_tx_pkg;
    localparam int DATA_W           = 7;
    localparam int MIN_FRAME_CYCLES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
// No state, no backpressure; any_req flags that at least one request is present.
module rr_pick
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = (ptr == LAST) ? '0 : ptr + ID_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = (cand == LAST) ? '0 : cand + ID_W'(1);
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one serial transmitter; grant 1 cycle after request, then holds off for FRAME_CYCLES.
// Requests are ignored while busy; SERIAL_TX_ARBITER_STATS_EN adds frame_count and req_wait_max.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
`ifdef SERIAL_TX_ARBITER_STATS_EN
    ,
    output logic [15:0]               frame_count,
    output logic [7:0]                req_wait_max
`endif
);
    localparam int              CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 2);

    if (NUM_REQ < 2 || NUM_REQ > 16 || FRAME_CYCLES < MIN_FRAME_CYCLES) begin : g_bad_param
        $error("serial_tx_arbiter: illegal NUM_REQ or FRAME_CYCLES");
    end

    logic [DATA_W-1:0] words [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_W +: DATA_W];
    end

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    winner, gid_nxt;
    logic               any_req, start_nxt, busy_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [DATA_W-1:0]  data_nxt;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= ID_W'(NUM_REQ - 1);
            tx_start <= 1'b0;
            req_ack  <= '0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            tx_start <= start_nxt;
            req_ack  <= ack_nxt;
            tx_data  <= data_nxt;
            busy     <= busy_nxt;
            grant_id <= gid_nxt;
        end
    end

    // The slot counter loads FRAME_CYCLES-2 so the launch edge, the countdown and the
    // single IDLE arbitration edge add up to exactly FRAME_CYCLES between starts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        start_nxt = 1'b0;
        ack_nxt   = '0;
        data_nxt  = tx_data;
        busy_nxt  = busy;
        gid_nxt   = grant_id;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                    ptr_nxt   = winner;
                    start_nxt = 1'b1;
                    ack_nxt   = NUM_REQ'(1) << winner;
                    data_nxt  = words[winner];
                    busy_nxt  = 1'b1;
                    gid_nxt   = winner;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_TX_ARBITER_STATS_EN
    logic [7:0] wait_cnt [NUM_REQ];
    logic [7:0] wait_sample;

    // Wait includes the grant edge itself; the ack cycle is not counted toward the next word.
    assign wait_sample = (wait_cnt[winner] == 8'hFF) ? 8'hFF : wait_cnt[winner] + 8'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_count  <= '0;
            req_wait_max <= '0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
            if (start_nxt) begin
                frame_count <= frame_count + 16'd1;
                if (wait_sample > req_wait_max) req_wait_max <= wait_sample;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_nxt[i] || !req_valid[i])
                    wait_cnt[i] <= '0;
                else if (!req_ack[i] && wait_cnt[i] != 8'hFF)
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic against a slot-timing model.
module tb_serial_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 10;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [6:0]     tx_data;
    logic           busy;
    logic [1:0]     grant_id;
`ifdef SERIAL_TX_ARBITER_STATS_EN
    logic [15:0]    frame_count;
    logic [7:0]     req_wait_max;
`endif

    always #5 clk = ~clk;

    serial_tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(FRAME)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
`ifdef SERIAL_TX_ARBITER_STATS_EN
        ,
        .frame_count  (frame_count),
        .req_wait_max (req_wait_max)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a launch may happen on any edge at least FRAME edges after the
    // previous launch; busy covers the launch edge plus the following FRAME-2 edges.
    int           cyc = 0;
    int           last_launch;
    int           m_ptr;
    int           m_frames;
    logic         e_start, e_busy;
    logic [N-1:0] e_ack;
    logic [6:0]   e_data;
    int           e_gid;

    task automatic model_reset();
        last_launch = -1000;
        m_ptr       = N - 1;
        m_frames    = 0;
        e_start     = 1'b0;
        e_busy      = 1'b0;
        e_ack       = '0;
        e_data      = '0;
        e_gid       = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic [7*N-1:0] d);
        int w;
        e_start = 1'b0;
        e_ack   = '0;
        if (cyc - last_launch >= FRAME && v != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            last_launch = cyc;
            m_ptr       = w;
            m_frames    = m_frames + 1;
            e_start     = 1'b1;
            e_ack[w]    = 1'b1;
            e_data      = d[7*w +: 7];
            e_gid       = w;
        end
        e_busy = (cyc - last_launch <= FRAME - 2);
    endtask

    bit auto_req = 1'b0;

    task automatic tick();
        logic [N-1:0]   v;
        logic [7*N-1:0] d;
        v = req_valid;
        d = req_data;
        @(posedge clk);
        cyc++;
        if (rstn) model_edge(v, d);
        #1;
        if (auto_req) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    if ($urandom_range(1) == 0) req_valid[i] = 1'b0;
                    else req_data[7*i +: 7] = 7'($urandom);
                end else if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[7*i +: 7]  = 7'($urandom);
                end
            end
        end
    endtask

    bit chk_en = 1'b0;
    int last_start = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_start", 32'(tx_start), 32'(e_start));
            chk("req_ack", 32'(req_ack), 32'(e_ack));
            chk("tx_data", 32'(tx_data), 32'(e_data));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("grant_id", 32'(grant_id), 32'(e_gid));
`ifdef SERIAL_TX_ARBITER_STATS_EN
            chk("frame_count", 32'(frame_count), 32'(m_frames & 16'hFFFF));
`endif
            if (tx_start) begin
                if (last_start >= 0) chk("start_spacing_ok", 32'(cyc - last_start >= FRAME), 32'd1);
                last_start = cyc;
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        model_reset();
        last_start = -1;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic wait_start(output int gid, output int at, output int dat);
        gid = -1;
        at  = -1;
        dat = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx_start) begin
                gid = int'(grant_id);
                at  = cyc;
                dat = int'(tx_data);
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL wait_start: no tx_start within 40 cycles");
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_d [5] = '{'h11, 'h22, 'h33, 'h44, 'h11};

    initial begin
        int g, at, at0, d, prev;
        model_reset();
        tick();
        chk_en = 1'b1;

        // Single request from requester 0
        do_reset();
        req_valid      = 4'b0001;
        req_data[6:0]  = 7'h55;
        tick();
        chk("A_start", 32'(tx_start), 32'd1);
        chk("A_data", 32'(tx_data), 32'h55);
        chk("A_ack", 32'(req_ack), 32'b0001);
        chk("A_gid", 32'(grant_id), 32'd0);
        chk("A_busy", 32'(busy), 32'd1);
        req_valid = '0;
        tick();
        chk("A_start_pulse", 32'(tx_start), 32'd0);
        chk("A_ack_pulse", 32'(req_ack), 32'd0);
        repeat (12) tick();
        chk("A_idle", 32'(busy), 32'd0);

        // All four held valid: strict rotation, exact slot spacing
        do_reset();
        req_valid = 4'hF;
        req_data  = {7'h44, 7'h33, 7'h22, 7'h11};
        prev = -1;
        for (int j = 0; j < 5; j++) begin
            wait_start(g, at, d);
            chk("B_grant", 32'(g), 32'(exp_g[j]));
            chk("B_data", 32'(d), 32'(exp_d[j]));
            if (j > 0) chk("B_spacing", 32'(at - prev), 32'd10);
            prev = at;
        end
        req_valid = '0;
        repeat (12) tick();

        // Request 2 arrives mid-slot of a requester-0 frame
        do_reset();
        req_valid     = 4'b0001;
        req_data[6:0] = 7'h0A;
        wait_start(g, at0, d);
        chk("C_first", 32'(g), 32'd0);
        req_valid = '0;
        repeat (3) tick();
        req_valid       = 4'b0100;
        req_data[20:14] = 7'h3C;
        wait_start(g, at, d);
        chk("C_grant", 32'(g), 32'd2);
        chk("C_gap", 32'(at - at0), 32'd10);
        chk("C_data", 32'(d), 32'h3C);
        req_valid = '0;
        repeat (12) tick();

        // Pointer at 1, requesters 1 and 3 together: 3 first, then 1
        do_reset();
        req_valid      = 4'b0010;
        req_data[13:7] = 7'h21;
        wait_start(g, at, d);
        chk("D_first", 32'(g), 32'd1);
        req_valid       = 4'b1010;
        req_data[27:21] = 7'h63;
        wait_start(g, at, d);
        chk("D_second", 32'(g), 32'd3);
        wait_start(g, at, d);
        chk("D_third", 32'(g), 32'd1);
        req_valid = '0;
        repeat (12) tick();

        // Reset four cycles into a frame: pointer restarts, requester 0 wins next
        do_reset();
        req_valid = 4'b0010;
        wait_start(g, at, d);
        chk("E_first", 32'(g), 32'd1);
        req_valid       = 4'b0101;
        req_data[6:0]   = 7'h5A;
        req_data[20:14] = 7'h3C;
        repeat (4) tick();
        do_reset();
        wait_start(g, at, d);
        chk("E_after_rst_grant", 32'(g), 32'd0);
        chk("E_after_rst_data", 32'(d), 32'h5A);
        req_valid = '0;
        repeat (12) tick();

        // Random traffic against the model
        do_reset();
        auto_req = 1'b1;
        repeat (3000) tick();
        auto_req  = 1'b0;
        req_valid = '0;
        repeat (12) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one 7-bit even-parity serial transmitter among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's 7-bit word.
- Issues a single-cycle start pulse to the transmitter, then blocks new launches until the frame slot has elapsed.
- Sits between the command/producer blocks and the transmitter. The transmitter has no busy output, so this block owns all frame spacing.

Parameters:
- NUM_REQ, 4: number of requesters. Legal range 2..16.
- FRAME_CYCLES, 10: minimum clock cycles between successive tx_start assertions. This covers the start bit, 8 data/parity bits and the return to idle. Values below 10 are illegal; the simulation assertion fires at elaboration.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- req_valid, input, NUM_REQ: per-requester request. Must be held high until acknowledged.
- req_data, input, 7*NUM_REQ: flattened words. Requester i occupies bits [7i+6:7i]. Must be stable while req_valid[i] is high.
- req_ack, output, NUM_REQ: one-hot, one-cycle pulse. Signals that the word was taken.
- tx_start, output, 1: start pulse to the transmitter.
- tx_data, output, 7: word to the transmitter.
- busy, output, 1: high while a frame slot is in progress.
- grant_id, output, ID_W: index of the most recent winner.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE.
  - tx_start=0, tx_data=0, req_ack=0, busy=0, grant_id=0.
  - Slot counter=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts the slot immediately. No ack or start is replayed after reset. The transmitter shares rstn and aborts with it.
- All outputs are registered.
- States: IDLE, BUSY.
- IDLE, no req_valid bit set: hold. tx_start and req_ack stay 0.
- IDLE, any req_valid bit set, at edge E0:
  - Winner = first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Registers loaded: tx_data<=req_data[winner], tx_start<=1, req_ack[winner]<=1, grant_id<=winner, pointer<=winner, busy<=1.
  - Counter loads FRAME_CYCLES-2; state goes to BUSY.
- BUSY:
  - tx_start and req_ack clear on the first edge after E0. Both pulses are therefore exactly one cycle wide.
  - Counter decrements each cycle. When counter==0 at an edge: state goes to IDLE and busy<=0.
  - req_valid is ignored throughout BUSY.
- Latency:
  - req_valid rising while IDLE leads to tx_start high one cycle later.
  - The transmitter drives the start bit one cycle after that.
- Back-to-back requests: successive tx_start assertions are exactly FRAME_CYCLES cycles apart. They are never closer.
- Handshake:
  - The requester sees req_ack high for one cycle.
  - At the edge ending that cycle it must drop req_valid or present its next word.
  - Because of the slot length, a request still valid at the next arbitration is treated as a new word.
- tx_data holds its value after launch until the next grant. Only the start-cycle value is functionally required.
- Requests asserted during BUSY are arbitrated at the first IDLE cycle. There is no loss and no starvation: each active requester is served within NUM_REQ slots.
- Simultaneous requests: exactly one winner per slot.
- Non-winning requesters receive no ack and keep waiting.

Optional Feature:
- Macro: SERIAL_TX_ARBITER_STATS_EN.
- Defined:
  - Adds output frame_count[15:0], which increments on every tx_start and wraps 0xFFFF->0.
  - Adds output req_wait_max[7:0]: the largest number of cycles any requester held req_valid before its ack. Saturates at 0xFF.
  - Both reset to 0.
- Undefined: neither port nor any of its logic exists. Arbitration behaviour is identical in both builds.

Decomposition:
- Package serial_tx_pkg holds:
  - DATA_W=7.
  - MIN_FRAME_CYCLES=10.
  - The state enum {IDLE, BUSY}.
- Sub-module rr_pick:
  - Combinational.
  - Inputs: req vector, pointer. Outputs: winner index, any_req.
  - Parameterised by NUM_REQ.
- The FSM, counter, registered outputs and stats stay in serial_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0001 with req_data[6:0]=7'h55.
  - Expect tx_start one cycle later, tx_data=7'h55, req_ack=4'b0001 for one cycle, grant_id=0.
  - The transmitter line shows start 0, data LSB-first, parity, then 1.
- All four held valid with words 11/22/33/44: grant order 0,1,2,3,0, with tx_start spacing exactly 10 cycles.
- Request 2 asserted mid-BUSY of a request-0 frame: request 2 is granted at the first IDLE cycle, and no second tx_start occurs inside the slot.
- Requesters 1 and 3 simultaneous, pointer=1: requester 3 wins, then requester 1 is served next slot.
- rstn pulsed low 4 cycles after launch:
  - All outputs return to 0 immediately and busy=0.
  - The next grant after release goes to requester 0.
- STATS_EN build: 3 frames give frame_count=3. With requester 1 held 25 cycles before ack, req_wait_max=25.
